regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the next core revision.
- Generalises the single-write / two-read register file:
  - configurable width, depth and read/write port counts
  - optional write-to-read bypass
  - per-register busy scoreboard used by the hazard unit for issue stalls
- Sits between decode (read/issue) and writeback (write).
- Also provides a debug read port for the testbench and LED checker logic.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, constants and write-priority helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = $clog2(NREG);
  localparam int unsigned MAX_WR = 2;
  localparam int unsigned WSEL_W = $clog2(MAX_WR);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // Outcome of a write-port match: any hit, and index of the winning port
  typedef struct packed {
    logic              vld;
    logic [WSEL_W-1:0] idx;
  } wr_sel_t;

  // Highest-indexed matching write port wins, for both commit and bypass
  function automatic wr_sel_t wr_prio_sel(input logic [MAX_WR-1:0] hits);
    wr_sel_t sel;
    sel = '0;
    for (int unsigned w = 0; w < MAX_WR; w++) begin
      if (hits[w]) begin
        sel.vld = 1'b1;
        sel.idx = WSEL_W'(w);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or flush.
module regfile_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_iss_en,
  input  logic [AW-1:0]     i_iss_addr,
  input  logic              i_flush,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [NWR*AW-1:0] i_wr_addr,
  input  logic [NRD*AW-1:0] i_rs_addr,
  output logic [NRD-1:0]    o_rs_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] clr;

  // Registers receiving a committed write this cycle
  always_comb begin
    clr = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (i_wr_en[w]) clr[i_wr_addr[w*AW +: AW]] = 1'b1;
    end
    clr[0] = 1'b0;
  end

  // Next busy state: issue beats flush, flush beats writeback clear
  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (i_iss_en && (i_iss_addr == AW'(r))) busy_nxt[r] = 1'b1;
      else if (i_flush)                       busy_nxt[r] = 1'b0;
      else if (clr[r])                        busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // Per-port lookup; a same-cycle write masks busy when its value is bypassed
  always_comb begin
    o_rs_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      o_rs_busy[k] = busy[i_rs_addr[k*AW +: AW]];
      if ((BYPASS != 0) && clr[i_rs_addr[k*AW +: AW]]) o_rs_busy[k] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass and busy scoreboard.
module regfile_mp #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  output logic [NRD-1:0]      o_rs_busy,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_addr,
  input  logic                i_flush,
  input  logic [AW-1:0]       i_dbg_addr,
  output logic [XLEN-1:0]     o_dbg_data
);

  import regfile_pkg::MAX_WR;
  import regfile_pkg::wr_sel_t;
  import regfile_pkg::wr_prio_sel;

  logic [XLEN-1:0]   regs   [NREG];
  logic [XLEN-1:0]   wd_s   [MAX_WR];
  logic [AW-1:0]     wa_s   [MAX_WR];
  logic [MAX_WR-1:0] we_s;
  logic [MAX_WR-1:0] w_hits [NREG];
  wr_sel_t           w_sel  [NREG];
  logic [MAX_WR-1:0] r_hits [NRD];
  wr_sel_t           r_sel  [NRD];

  // Unpack write ports into fixed-size arrays; unused slots stay idle
  always_comb begin
    for (int unsigned w = 0; w < MAX_WR; w++) begin
      we_s[w] = 1'b0;
      wa_s[w] = '0;
      wd_s[w] = '0;
    end
    for (int unsigned w = 0; w < NWR; w++) begin
      we_s[w] = i_wr_en[w];
      wa_s[w] = i_wr_addr[w*AW +: AW];
      wd_s[w] = i_wr_data[w*XLEN +: XLEN];
    end
  end

  // Per-register write port selection with port priority
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      w_hits[r] = '0;
      for (int unsigned w = 0; w < MAX_WR; w++) begin
        w_hits[r][w] = we_s[w] && (wa_s[w] == AW'(r)) && (r != 0);
      end
      w_sel[r] = wr_prio_sel(w_hits[r]);
    end
  end

  // Register storage; x0 is held at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      regs[0] <= '0;
      for (int unsigned r = 1; r < NREG; r++) begin
        if (w_sel[r].vld) regs[r] <= wd_s[w_sel[r].idx];
      end
    end
  end

  // Combinational read ports with optional bypass of same-cycle writes
  always_comb begin
    o_rs_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      r_hits[k] = '0;
      for (int unsigned w = 0; w < MAX_WR; w++) begin
        r_hits[k][w] = i_rst_n && we_s[w] &&
                       (wa_s[w] == i_rs_addr[k*AW +: AW]) &&
                       (i_rs_addr[k*AW +: AW] != '0);
      end
      r_sel[k] = wr_prio_sel(r_hits[k]);
      if ((BYPASS != 0) && r_sel[k].vld)
        o_rs_data[k*XLEN +: XLEN] = wd_s[r_sel[k].idx];
      else
        o_rs_data[k*XLEN +: XLEN] = regs[i_rs_addr[k*AW +: AW]];
    end
  end

  // Debug port sees stored state only
  assign o_dbg_data = regs[i_dbg_addr];

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_rs_addr  (i_rs_addr),
    .o_rs_busy  (o_rs_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default parameters, bypass enabled).
module tb_regfile_mp;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_data;
  logic [NRD-1:0]      o_rs_busy;
  logic [NWR-1:0]      i_wr_en;
  logic [NWR*AW-1:0]   i_wr_addr;
  logic [NWR*XLEN-1:0] i_wr_data;
  logic                i_iss_en;
  logic [AW-1:0]       i_iss_addr;
  logic                i_flush;
  logic [AW-1:0]       i_dbg_addr;
  logic [XLEN-1:0]     o_dbg_data;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  regfile_mp dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rs_addr  (i_rs_addr),
    .o_rs_data  (o_rs_data),
    .o_rs_busy  (o_rs_busy),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_iss_en   (i_iss_en),
    .i_iss_addr (i_iss_addr),
    .i_flush    (i_flush),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    i_rs_addr = {a1, a0};
  endtask

  task automatic set_wr(input logic e0, input logic [AW-1:0] a0, input logic [31:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [31:0] d1);
    i_wr_en   = {e1, e0};
    i_wr_addr = {a1, a0};
    i_wr_data = {d1, d0};
  endtask

  function automatic logic [31:0] rd(input int k);
    return o_rs_data[k*XLEN +: XLEN];
  endfunction

  initial begin
    i_rst_n = 1'b0;
    i_iss_en = 1'b0; i_iss_addr = '0; i_flush = 1'b0; i_dbg_addr = '0;
    set_rd(5'd1, 5'd31);
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // 1. reset then read
    repeat (3) tick();
    i_rst_n = 1'b1;
    i_dbg_addr = 5'd1;
    #1;
    check("rst_rd0_x1", rd(0), 32'h0);
    check("rst_rd1_x31", rd(1), 32'h0);
    check("rst_busy", 32'(o_rs_busy), 32'h0);
    check("rst_dbg", o_dbg_data, 32'h0);

    // 2. write x5 with same-cycle read
    tick();
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    set_rd(5'd5, 5'd1);
    i_dbg_addr = 5'd5;
    #1;
    check("byp_x5", rd(0), 32'hDEADBEEF);
    check("dbg_x5_pre", o_dbg_data, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("dbg_x5_post", o_dbg_data, 32'hDEADBEEF);
    check("rd_x5_post", rd(0), 32'hDEADBEEF);

    // 3. write conflict on x8: port1 wins
    set_wr(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
    set_rd(5'd8, 5'd5);
    #1;
    check("conf_byp", rd(0), 32'h22);
    check("conf_rd1_x5", rd(1), 32'hDEADBEEF);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_dbg_addr = 5'd8;
    #1;
    check("conf_rd", rd(0), 32'h22);
    check("conf_dbg", o_dbg_data, 32'h22);

    // 4. x0 protection
    set_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
    i_iss_en = 1'b1; i_iss_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    check("x0_byp", rd(0), 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_iss_en = 1'b0;
    i_dbg_addr = 5'd0;
    #1;
    check("x0_rd", rd(1), 32'h0);
    check("x0_busy", 32'(o_rs_busy), 32'h0);
    check("x0_dbg", o_dbg_data, 32'h0);

    // 5. scoreboard
    i_iss_en = 1'b1; i_iss_addr = 5'd3;
    set_rd(5'd3, 5'd8);
    #1;
    check("sb_busy_pre", 32'(o_rs_busy), 32'h0);
    tick();
    i_iss_en = 1'b0;
    #1;
    check("sb_busy_set", 32'(o_rs_busy), 32'h1);
    set_wr(1'b1, 5'd3, 32'h7, 1'b0, 5'd0, 32'h0);
    i_iss_en = 1'b1; i_iss_addr = 5'd3;
    #1;
    check("sb_wb_byp_data", rd(0), 32'h7);
    check("sb_wb_byp_busy", 32'(o_rs_busy), 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_iss_en = 1'b0;
    #1;
    check("sb_reiss_busy", 32'(o_rs_busy), 32'h1);
    check("sb_reiss_data", rd(0), 32'h7);
    set_wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h9);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    check("sb_clr_busy", 32'(o_rs_busy), 32'h0);
    check("sb_clr_data", rd(0), 32'h9);

    // 6. flush with same-cycle issue
    i_iss_en = 1'b1; i_iss_addr = 5'd2;
    tick();
    i_iss_addr = 5'd9;
    tick();
    i_iss_en = 1'b0;
    set_rd(5'd2, 5'd9);
    #1;
    check("fl_busy_pre", 32'(o_rs_busy), 32'h3);
    i_flush = 1'b1; i_iss_en = 1'b1; i_iss_addr = 5'd4;
    tick();
    i_flush = 1'b0; i_iss_en = 1'b0;
    #1;
    check("fl_busy_2_9", 32'(o_rs_busy), 32'h0);
    set_rd(5'd4, 5'd2);
    #1;
    check("fl_busy_4", 32'(o_rs_busy), 32'h1);

    // reset asserted mid-cycle during a write to x4
    set_wr(1'b1, 5'd4, 32'hAB, 1'b0, 5'd0, 32'h0);
    i_dbg_addr = 5'd5;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(o_rs_busy), 32'h0);
    check("mrst_rd_x4", rd(0), 32'h0);
    check("mrst_dbg_x5", o_dbg_data, 32'h0);
    tick();
    set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_rst_n = 1'b1;
    i_dbg_addr = 5'd4;
    #1;
    check("mrst_dbg_x4", o_dbg_data, 32'h0);
    set_rd(5'd8, 5'd3);
    #1;
    check("mrst_rd_x8", rd(0), 32'h0);
    check("mrst_rd_x3", rd(1), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
